p_sched_arb: RTL and testbench

Registered, parametrised successor to the combinational priority select used in the scheduler datapath. It arbitrates among N request channels, each carrying a W-bit payload, in either fixed-priority mode (lowest index wins) or round-robin mode. It latches the winning payload and holds it behind a valid/ready handshake. The block sits between the task-request front end and the dispatch stage, and grants at most one channel per accepted transfer.

---
 rtl/p_sched_arb.sv | 154 +++++++++++++++
 tb/tb_p_sched_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/p_sched_arb.sv
// ---------------------------------------------------------------------------
// p_sched_arb
//
// Registered request arbiter for the scheduler datapath. Picks one of N
// request channels per arbitration cycle, using either fixed priority
// (channel 0 highest) or round-robin order. It then latches the winner's
// payload and holds it behind a valid/ready handshake until downstream
// accepts it.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   mode       0 = fixed priority, 1 = round-robin
//   req        per-channel request bits [N-1:0]
//   data       packed payloads, channel i at data[i*W +: W]
//   out_ready  downstream accepts the currently held grant
//   out_valid  a grant is being held
//   out_data   latched payload of the granted channel
//   out_grant  one-hot granted channel, zero while out_valid is low
//   out_idx    binary index of the granted channel
//   rr_ptr     round-robin search start index (observability)
// ---------------------------------------------------------------------------
module p_sched_arb #(
    parameter int N = 8,
    parameter int W = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [N-1:0]     out_grant,
    output logic [IW-1:0]    out_idx,
    output logic [IW-1:0]    rr_ptr
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  data_q, data_d;
    logic [IW-1:0] rrPtr_q, rrPtr_d;

    logic          arbCycle;
    logic          anyReq;
    logic [IW-1:0] fixIdx;
    logic [IW-1:0] rrIdx;
    logic          rrFound;
    int            rrPos;
    logic [IW-1:0] winner;
    logic [N-1:0]  winOneHot;
    logic [W-1:0]  winData;
    logic [IW-1:0] nextPtr;

    // A new decision may be taken whenever nothing is held or the held
    // grant is being accepted on this edge.
    assign arbCycle = (state_q == EMPTY) || out_ready;
    assign anyReq   = |req;

    // Fixed priority: scanning downward so the lowest set index is the
    // last assignment and therefore wins.
    always_comb begin
        fixIdx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                fixIdx = IW'(i);
            end
        end
    end

    // Round-robin: walk N positions starting at rrPtr_q, wrapping by
    // subtraction rather than masking so non-power-of-two N works.
    always_comb begin
        rrIdx   = '0;
        rrFound = 1'b0;
        rrPos   = 0;
        for (int off = 0; off < N; off++) begin
            rrPos = int'(rrPtr_q) + off;
            if (rrPos >= N) begin
                rrPos = rrPos - N;
            end
            if (!rrFound && req[rrPos[IW-1:0]]) begin
                rrIdx   = rrPos[IW-1:0];
                rrFound = 1'b1;
            end
        end
    end

    // Winner, its one-hot grant, its payload and the pointer that would
    // follow it.
    assign winner    = mode ? rrIdx : fixIdx;
    assign winOneHot = {{(N-1){1'b0}}, 1'b1} << winner;
    assign winData   = data[int'(winner)*W +: W];
    assign nextPtr   = (winner == IW'(N - 1)) ? '0 : winner + IW'(1);

    // Next-state decision. Outside an arbitration cycle everything holds,
    // which is what freezes the outputs under backpressure. With no
    // requests the grant drops but index and payload keep their last
    // values.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        data_d  = data_q;
        rrPtr_d = rrPtr_q;
        if (arbCycle) begin
            if (anyReq) begin
                state_d = HELD;
                grant_d = winOneHot;
                idx_d   = winner;
                data_d  = winData;
                if (mode) begin
                    rrPtr_d = nextPtr;
                end
            end else begin
                state_d = EMPTY;
                grant_d = '0;
            end
        end
    end

    // All outputs come straight from these registers; reset wins over a
    // grant that is still waiting for acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            grant_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            rrPtr_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rrPtr_q <= rrPtr_d;
        end
    end

    assign out_valid = (state_q == HELD);
    assign out_grant = grant_q;
    assign out_idx   = idx_q;
    assign out_data  = data_q;
    assign rr_ptr    = rrPtr_q;

endmodule

// File: tb/tb_p_sched_arb.sv
// ---------------------------------------------------------------------------
// tb_p_sched_arb
//
// Directed bench for p_sched_arb with N=8, W=8. A table of per-cycle
// vectors covers reset, fixed priority, round-robin skip/wrap and mode
// switching. Hand-written sequences cover round-robin fairness over a full
// lap, backpressure hold and reset in the middle of a handshake.
// ---------------------------------------------------------------------------
module tb_p_sched_arb;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int IW = 3;

    // Channel payloads: ch0=11 ch1=22 ch2=5A ch3=C3 ch4=44 ch5=55 ch6=66 ch7=77
    localparam logic [63:0] DATA_A = 64'h7766_5544_C35A_2211;
    // Same as DATA_A but with channel 3 cleared
    localparam logic [63:0] DATA_B = 64'h7766_5544_005A_2211;

    logic            clk;
    logic            rst;
    logic            mode;
    logic [N-1:0]    req;
    logic [N*W-1:0]  data;
    logic            outReady;
    logic            outValid;
    logic [W-1:0]    outData;
    logic [N-1:0]    outGrant;
    logic [IW-1:0]   outIdx;
    logic [IW-1:0]   rrPtr;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic          rst;
        logic          mode;
        logic [7:0]    req;
        logic [63:0]   data;
        logic          rdy;
        logic          expValid;
        logic [7:0]    expGrant;
        logic [2:0]    expIdx;
        logic [7:0]    expData;
        logic [2:0]    expRr;
    } vec_t;

    vec_t vecs[18];

    p_sched_arb #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .req       (req),
        .data      (data),
        .out_ready (outReady),
        .out_valid (outValid),
        .out_data  (outData),
        .out_grant (outGrant),
        .out_idx   (outIdx),
        .rr_ptr    (rrPtr)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one vector, let one rising edge pass, and settle 1 time unit
    // after it so outputs are sampled away from the edge.
    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        mode     = v.mode;
        req      = v.req;
        data     = v.data;
        outReady = v.rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkField({tag, " valid"}, 32'(outValid), 32'(v.expValid));
        checkField({tag, " grant"}, 32'(outGrant), 32'(v.expGrant));
        checkField({tag, " idx"},   32'(outIdx),   32'(v.expIdx));
        checkField({tag, " data"},  32'(outData),  32'(v.expData));
        checkField({tag, " rr"},    32'(rrPtr),    32'(v.expRr));
    endtask

    function automatic vec_t mk(input logic r, input logic m, input logic [7:0] q,
                                input logic [63:0] d, input logic rd,
                                input logic ev, input logic [7:0] eg, input logic [2:0] ei,
                                input logic [7:0] ed, input logic [2:0] er);
        vec_t v;
        v.rst = r; v.mode = m; v.req = q; v.data = d; v.rdy = rd;
        v.expValid = ev; v.expGrant = eg; v.expIdx = ei; v.expData = ed; v.expRr = er;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [7:0] chanData[8];
        int idx;

        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        mode        = 1'b0;
        req         = '0;
        data        = DATA_A;
        outReady    = 1'b0;

        for (int c = 0; c < 8; c++) begin
            chanData[c] = DATA_A[c*8 +: 8];
        end

        //           rst   mode  req     data    rdy  | valid grant  idx  data   rr
        vecs[0]  = mk(1'b1, 1'b0, 8'hFF, DATA_A, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 3'd0);
        vecs[1]  = mk(1'b1, 1'b0, 8'hFF, DATA_A, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 3'd0);
        vecs[2]  = mk(1'b0, 1'b0, 8'h00, DATA_A, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 3'd0);
        vecs[3]  = mk(1'b0, 1'b0, 8'h00, DATA_A, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 3'd0);
        vecs[4]  = mk(1'b0, 1'b0, 8'hA4, DATA_A, 1'b1, 1'b1, 8'h04, 3'd2, 8'h5A, 3'd0);
        vecs[5]  = mk(1'b0, 1'b0, 8'hA4, DATA_A, 1'b1, 1'b1, 8'h04, 3'd2, 8'h5A, 3'd0);
        vecs[6]  = mk(1'b0, 1'b0, 8'hA4, DATA_A, 1'b1, 1'b1, 8'h04, 3'd2, 8'h5A, 3'd0);
        vecs[7]  = mk(1'b0, 1'b0, 8'h00, DATA_A, 1'b1, 1'b0, 8'h00, 3'd2, 8'h5A, 3'd0);
        vecs[8]  = mk(1'b0, 1'b0, 8'h80, DATA_A, 1'b0, 1'b1, 8'h80, 3'd7, 8'h77, 3'd0);
        vecs[9]  = mk(1'b0, 1'b0, 8'h01, DATA_A, 1'b0, 1'b1, 8'h80, 3'd7, 8'h77, 3'd0);
        vecs[10] = mk(1'b0, 1'b0, 8'h01, DATA_A, 1'b1, 1'b1, 8'h01, 3'd0, 8'h11, 3'd0);
        vecs[11] = mk(1'b0, 1'b1, 8'h20, DATA_A, 1'b1, 1'b1, 8'h20, 3'd5, 8'h55, 3'd6);
        vecs[12] = mk(1'b0, 1'b1, 8'h09, DATA_A, 1'b1, 1'b1, 8'h01, 3'd0, 8'h11, 3'd1);
        vecs[13] = mk(1'b0, 1'b1, 8'h09, DATA_A, 1'b1, 1'b1, 8'h08, 3'd3, 8'hC3, 3'd4);
        vecs[14] = mk(1'b0, 1'b1, 8'h09, DATA_A, 1'b1, 1'b1, 8'h01, 3'd0, 8'h11, 3'd1);
        vecs[15] = mk(1'b0, 1'b0, 8'h0A, DATA_A, 1'b1, 1'b1, 8'h02, 3'd1, 8'h22, 3'd1);
        vecs[16] = mk(1'b0, 1'b1, 8'h0A, DATA_A, 1'b1, 1'b1, 8'h02, 3'd1, 8'h22, 3'd2);
        vecs[17] = mk(1'b0, 1'b1, 8'h00, DATA_A, 1'b1, 1'b0, 8'h00, 3'd1, 8'h22, 3'd2);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Round-robin fairness: full request set, indices walk 0..7 then wrap.
        applyStimulus(mk(1'b1, 1'b1, 8'h00, DATA_A, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 3'd0));
        checkOutput("rrReset", mk(1'b1, 1'b1, 8'h00, DATA_A, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 3'd0));
        for (int k = 0; k < 9; k++) begin
            idx = k % 8;
            v = mk(1'b0, 1'b1, 8'hFF, DATA_A, 1'b1, 1'b1, 8'h01 << idx, 3'(idx),
                   chanData[idx], 3'((idx + 1) % 8));
            applyStimulus(v);
            checkOutput($sformatf("rrFair%0d", k), v);
        end

        // Backpressure: take a grant on channel 3, then stall 4 cycles while
        // req and data[3] change underneath it.
        applyStimulus(mk(1'b1, 1'b0, 8'h00, DATA_A, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 3'd0));
        v = mk(1'b0, 1'b0, 8'h08, DATA_A, 1'b1, 1'b1, 8'h08, 3'd3, 8'hC3, 3'd0);
        applyStimulus(v);
        checkOutput("bpGrant", v);
        for (int k = 0; k < 4; k++) begin
            v = mk(1'b0, 1'b0, 8'h01, DATA_B, 1'b0, 1'b1, 8'h08, 3'd3, 8'hC3, 3'd0);
            applyStimulus(v);
            checkOutput($sformatf("bpHold%0d", k), v);
        end
        v = mk(1'b0, 1'b0, 8'h01, DATA_B, 1'b1, 1'b1, 8'h01, 3'd0, 8'h11, 3'd0);
        applyStimulus(v);
        checkOutput("bpRelease", v);

        // Reset mid-handshake: held grant on channel 4 in round-robin mode,
        // reset drops it, then arbitration resumes from pointer 0.
        v = mk(1'b0, 1'b1, 8'h10, DATA_A, 1'b1, 1'b1, 8'h10, 3'd4, 8'h44, 3'd5);
        applyStimulus(v);
        checkOutput("midGrant", v);
        v = mk(1'b0, 1'b1, 8'h10, DATA_A, 1'b0, 1'b1, 8'h10, 3'd4, 8'h44, 3'd5);
        applyStimulus(v);
        checkOutput("midStall", v);
        v = mk(1'b1, 1'b1, 8'h10, DATA_A, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 3'd0);
        applyStimulus(v);
        checkOutput("midReset", v);
        v = mk(1'b0, 1'b1, 8'h10, DATA_A, 1'b0, 1'b1, 8'h10, 3'd4, 8'h44, 3'd5);
        applyStimulus(v);
        checkOutput("midResume", v);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
